adc_seq_sampler: RTL

- Parametrised successor to the single-channel die-temperature capture.
- Drives the modular ADC command/response streams itself, stepping round-robin through up to 8 configured channels at a programmable sample rate.
- For each channel: subtracts a fixed offset with saturation, averages 2^AVG_LOG2 samples, and publishes a result with a one-cycle valid strobe.
- Tracks an over-temperature alarm with hysteresis on channel slot 0.
- Sits between adc_qsys and the bin2bcd/seg7 display path.

---
 rtl/adc_seq_sampler.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_seq_sampler.sv
// adc_seq_sampler: round-robin ADC sequencer with offset saturation, 2^AVG_LOG2 averaging and slot-0 alarm.
// Define ADC_SEQ_MINMAX_EN to add min/max tracking of slot-0 results (min_data, max_data, minmax_clear).
module adc_seq_sampler #(
  parameter int          NUM_CH       = 2,
  parameter logic [39:0] CH_LIST      = 40'h00_0000_0031,
  parameter int          SAMPLE_DIV   = 100000,
  parameter int          AVG_LOG2     = 2,
  parameter logic [11:0] OFFSET       = 12'd3431,
  parameter logic [11:0] ALARM_SET    = 12'd300,
  parameter logic [11:0] ALARM_CLR    = 12'd250,
  parameter int          RESP_TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  output logic        result_valid,
  output logic [2:0]  result_slot,
  output logic [4:0]  result_channel,
  output logic [11:0] result_data,
  output logic        alarm,
  output logic [7:0]  err_count
`ifdef ADC_SEQ_MINMAX_EN
  ,
  input  logic        minmax_clear,
  output logic [11:0] min_data,
  output logic [11:0] max_data
`endif
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int TO_W  = $clog2(RESP_TIMEOUT + 1);
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(1 << AVG_LOG2);
  localparam logic [2:0]       SLOT_LAST = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_WAIT,
    S_ISSUE,
    S_RESP,
    S_ACCUM,
    S_EMIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DIV_W-1:0] r_div;
  logic [TO_W-1:0]  r_to;
  logic [2:0]       r_slot;
  logic [11:0]      r_raw;
  logic [ACC_W-1:0] r_acc [8];
  logic [CNT_W-1:0] r_cnt [8];

  logic        r_result_valid;
  logic [2:0]  r_result_slot;
  logic [4:0]  r_result_channel;
  logic [11:0] r_result_data;
  logic        r_alarm;
  logic [7:0]  r_err;

  logic             w_tick;
  logic [2:0]       w_slot_nx;
  logic [5:0]       w_base;
  logic [4:0]       w_slot_ch;
  logic             w_match;
  logic             w_mismatch;
  logic             w_timeout;
  logic             w_err_inc;
  logic [11:0]      w_corr;
  logic [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_full;
  logic [11:0]      w_avg;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_slot_nx  = (r_slot == SLOT_LAST) ? 3'd0 : r_slot + 3'd1;
  assign w_base     = {1'b0, r_slot, 2'b00} + {3'b000, r_slot};
  assign w_slot_ch  = CH_LIST[w_base +: 5];

  assign w_match    = response_valid && (response_channel == w_slot_ch);
  assign w_mismatch = response_valid && (response_channel != w_slot_ch);
  assign w_timeout  = (r_to == TO_LAST);
  assign w_err_inc  = (r_state == S_RESP) && !w_match && (w_timeout || w_mismatch);

  assign w_corr     = (r_raw >= OFFSET) ? r_raw - OFFSET : '0;
  assign w_sum      = r_acc[r_slot] + ACC_W'(w_corr);
  assign w_cnt_nx   = r_cnt[r_slot] + CNT_W'(1);
  assign w_full     = (w_cnt_nx == CNT_FULL);
  assign w_avg      = 12'(w_sum >> AVG_LOG2);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    command_valid   = 1'b0;
    command_channel = '0;
    case (r_state)
      S_WAIT: begin
        if (w_tick && enable) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        command_valid   = 1'b1;
        command_channel = w_slot_ch;
        if (command_ready) w_next = S_RESP;
      end
      S_RESP: begin
        if (w_match)        w_next = S_ACCUM;
        else if (w_timeout) w_next = S_WAIT;
      end
      S_ACCUM: begin
        w_next = w_full ? S_EMIT : S_WAIT;
      end
      S_EMIT: begin
        w_next = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
  end

  // Result, alarm and min/max are registered on the ACCUM->EMIT edge so they are
  // visible during the EMIT cycle, two cycles after the matching response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div            <= '0;
      r_to             <= '0;
      r_slot           <= '0;
      r_raw            <= '0;
      r_result_valid   <= 1'b0;
      r_result_slot    <= '0;
      r_result_channel <= '0;
      r_result_data    <= '0;
      r_alarm          <= 1'b0;
      r_err            <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_div          <= w_tick ? '0 : r_div + DIV_W'(1);
      r_to           <= (r_state == S_RESP) ? r_to + TO_W'(1) : '0;
      r_result_valid <= 1'b0;

      if (w_err_inc && (r_err != 8'hFF)) r_err <= r_err + 8'd1;

      case (r_state)
        S_RESP: begin
          if (w_match)        r_raw  <= response_data;
          else if (w_timeout) r_slot <= w_slot_nx;
        end
        S_ACCUM: begin
          r_acc[r_slot] <= w_sum;
          r_cnt[r_slot] <= w_cnt_nx;
          if (w_full) begin
            r_result_valid   <= 1'b1;
            r_result_slot    <= r_slot;
            r_result_channel <= w_slot_ch;
            r_result_data    <= w_avg;
            if (r_slot == 3'd0) begin
              if (w_avg >= ALARM_SET)     r_alarm <= 1'b1;
              else if (w_avg < ALARM_CLR) r_alarm <= 1'b0;
            end
          end else begin
            r_slot <= w_slot_nx;
          end
        end
        S_EMIT: begin
          r_acc[r_slot] <= '0;
          r_cnt[r_slot] <= '0;
          r_slot        <= w_slot_nx;
        end
        default: ;
      endcase
    end
  end

  assign result_valid   = r_result_valid;
  assign result_slot    = r_result_slot;
  assign result_channel = r_result_channel;
  assign result_data    = r_result_data;
  assign alarm          = r_alarm;
  assign err_count      = r_err;

`ifdef ADC_SEQ_MINMAX_EN
  logic [11:0] r_min;
  logic [11:0] r_max;
  logic        w_mm_upd;

  assign w_mm_upd = (r_state == S_ACCUM) && w_full && (r_slot == 3'd0);

  always_ff @(posedge clock) begin
    if (reset || minmax_clear) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_mm_upd) begin
      if (w_avg < r_min) r_min <= w_avg;
      if (w_avg > r_max) r_max <= w_avg;
    end
  end

  assign min_data = r_min;
  assign max_data = r_max;
`endif

endmodule
